td4_prog_loader: RTL and testbench

//  Serial program loader for the TD4 core: receives a 16-byte program over UART (8N1)
//  and writes it into the core's 16x8 program RAM (the RAM's write side; the core fetches).

---
 rtl/td4_prog_loader.sv | 198 +++++++++++++++++++
 tb/tb_td4_prog_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/td4_prog_loader.sv
// td4_prog_loader
//   Serial program loader for the TD4 core. Receives a frame over UART 8N1
//   (SYNC byte, 16 data bytes for addresses 0..15, 1 checksum byte). It writes
//   each data byte into the core's 16x8 program RAM and holds the core in reset
//   until a frame with a matching 8-bit additive checksum has been loaded.
// Ports
//   CLK        system clock
//   RST        synchronous reset, active-low
//   RXD        UART receive line (asynchronous, idle high)
//   prog_we    program RAM write strobe, one cycle per data byte
//   prog_adr   program RAM write address
//   prog_din   program RAM write data (opcode[7:4], immediate[3:0])
//   cpu_rst_n  core reset, active-low
//   busy       frame in progress
//   done       last frame loaded with good checksum (sticky)
//   err_code   0 none, 1 framing, 2 timeout, 3 checksum (sticky until next sync)
module td4_prog_loader #(
   parameter int       CLK_HZ      = 50_000_000,
   parameter int       BAUD        = 9600,
   parameter bit [7:0] SYNC        = 8'hA5,
   parameter int       TIMEOUT_CYC = 5_000_000,
   parameter bit       BOOT_HOLD   = 1'b1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RXD,
   output logic       prog_we,
   output logic [3:0] prog_adr,
   output logic [7:0] prog_din,
   output logic       cpu_rst_n,
   output logic       busy,
   output logic       done,
   output logic [1:0] err_code
);

   localparam int DIV = CLK_HZ / BAUD;
   localparam int BW  = $clog2(DIV + 1);
   localparam int TW  = $clog2(TIMEOUT_CYC + 1);

   localparam logic [BW-1:0] BAUD_HALF = BW'(DIV / 2 - 1);
   localparam logic [BW-1:0] BAUD_FULL = BW'(DIV - 1);
   localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {IDLE, DATA, CSUM, DONE, ERR} state_t;

   // ------------------------------------------------------------------
   // UART receive engine
   // ------------------------------------------------------------------
   rx_state_t       rx_state;
   logic            rxd_s1, rxd_s2, rxd_prev;
   logic [BW-1:0]   baud_cnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      rx_shift;
   logic            rx_valid;
   logic            rx_ferr;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         rxd_s1   <= 1'b1;
         rxd_s2   <= 1'b1;
         rxd_prev <= 1'b1;
         rx_state <= RX_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         rx_shift <= '0;
      end else begin
         rxd_s1   <= RXD;
         rxd_s2   <= rxd_s1;
         rxd_prev <= rxd_s2;
         case (rx_state)
            RX_IDLE: begin
               if (rxd_prev && !rxd_s2) begin
                  baud_cnt <= BAUD_HALF;
                  rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (baud_cnt == '0) begin
                  // Start bit re-checked at mid-bit; a high line means a glitch.
                  if (!rxd_s2) begin
                     baud_cnt <= BAUD_FULL;
                     bit_cnt  <= '0;
                     rx_state <= RX_DATA;
                  end else begin
                     rx_state <= RX_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
            RX_DATA: begin
               if (baud_cnt == '0) begin
                  rx_shift <= {rxd_s2, rx_shift[7:1]};
                  baud_cnt <= BAUD_FULL;
                  if (bit_cnt == 3'd7) rx_state <= RX_STOP;
                  else                 bit_cnt  <= bit_cnt + 1'b1;
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
            RX_STOP: begin
               if (baud_cnt == '0) rx_state <= RX_IDLE;
               else                baud_cnt <= baud_cnt - 1'b1;
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   // Byte completion is decoded at the stop-bit sample itself so the frame
   // FSM registers its write strobe on that same edge.
   always_comb begin
      rx_valid = 1'b0;
      rx_ferr  = 1'b0;
      if (rx_state == RX_STOP && baud_cnt == '0) begin
         rx_valid = rxd_s2;
         rx_ferr  = !rxd_s2;
      end
   end

   // ------------------------------------------------------------------
   // Frame FSM
   // ------------------------------------------------------------------
   state_t        state;
   logic [3:0]    cnt;
   logic [7:0]    sum;
   logic [TW-1:0] tmo_cnt;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state     <= IDLE;
         prog_we   <= 1'b0;
         prog_adr  <= '0;
         prog_din  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err_code  <= 2'd0;
         cpu_rst_n <= ~BOOT_HOLD;
         cnt       <= '0;
         sum       <= '0;
         tmo_cnt   <= '0;
      end else begin
         prog_we <= 1'b0;
         case (state)
            IDLE, DONE, ERR: begin
               if (rx_valid && rx_shift == SYNC) begin
                  state     <= DATA;
                  cnt       <= '0;
                  sum       <= '0;
                  tmo_cnt   <= '0;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  err_code  <= 2'd0;
                  cpu_rst_n <= 1'b0;
               end
            end
            DATA, CSUM: begin
               if (rx_valid) begin
                  tmo_cnt <= '0;
                  if (state == DATA) begin
                     prog_we  <= 1'b1;
                     prog_adr <= cnt;
                     prog_din <= rx_shift;
                     sum      <= sum + rx_shift;
                     cnt      <= cnt + 1'b1;
                     if (cnt == 4'hF) state <= CSUM;
                  end else if (rx_shift == sum) begin
                     state     <= DONE;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     cpu_rst_n <= 1'b1;
                  end else begin
                     state    <= ERR;
                     err_code <= 2'd3;
                     busy     <= 1'b0;
                  end
               end else if (rx_ferr) begin
                  state    <= ERR;
                  err_code <= 2'd1;
                  busy     <= 1'b0;
               end else if (tmo_cnt == TMO_LAST) begin
                  state    <= ERR;
                  err_code <= 2'd2;
                  busy     <= 1'b0;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_td4_prog_loader.sv
`timescale 1ns/1ps
module tb_td4_prog_loader;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       RXD = 1'b1;
   logic       prog_we;
   logic [3:0] prog_adr;
   logic [7:0] prog_din;
   logic       cpu_rst_n;
   logic       busy;
   logic       done;
   logic [1:0] err_code;

   int n_cmp = 0;
   int n_bad = 0;

   td4_prog_loader #(
      .CLK_HZ(16), .BAUD(1), .SYNC(8'hA5), .TIMEOUT_CYC(400), .BOOT_HOLD(1'b1)
   ) dut (
      .CLK(CLK), .RST(RST), .RXD(RXD), .prog_we(prog_we), .prog_adr(prog_adr),
      .prog_din(prog_din), .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done),
      .err_code(err_code)
   );

   always #5 CLK = ~CLK;

   // Write log and observed RAM image, captured away from the active edge.
   logic [3:0] wr_adr[$];
   logic [7:0] wr_din[$];
   logic [7:0] ram_seen [16];
   logic [7:0] ram_model[16];
   logic [7:0] frm[16];

   always @(negedge CLK) begin
      if (prog_we === 1'b1) begin
         wr_adr.push_back(prog_adr);
         wr_din.push_back(prog_din);
         ram_seen[prog_adr] = prog_din;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, summary not reached");
      $fatal(1, "watchdog");
   end

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // 8N1 at 16 clocks per bit, followed by a short idle gap.
   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      RXD = 1'b0;
      idle(16);
      for (int i = 0; i < 8; i++) begin
         RXD = b[i];
         idle(16);
      end
      RXD = stop_bit;
      idle(16);
      RXD = 1'b1;
      idle(4);
   endtask

   task automatic send_frame(input logic [7:0] cs);
      send_byte(8'hA5, 1'b1);
      for (int i = 0; i < 16; i++) send_byte(frm[i], 1'b1);
      send_byte(cs, 1'b1);
   endtask

   function automatic logic [7:0] model_sum();
      int s = 0;
      for (int i = 0; i < 16; i++) s += int'(frm[i]);
      return 8'(s % 256);
   endfunction

   task automatic clear_log();
      wr_adr.delete();
      wr_din.delete();
   endtask

   task automatic test_reset();
      RST = 1'b0;
      idle(2);
      n_cmp++; if (cpu_rst_n !== 1'b0) begin n_bad++; $display("FAIL reset_cpu_rst_n: got %b want 0", cpu_rst_n); end
      n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0)      begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
      n_cmp++; if (err_code !== 2'd0)  begin n_bad++; $display("FAIL reset_err: got %0d want 0", err_code); end
      n_cmp++; if (prog_we !== 1'b0)   begin n_bad++; $display("FAIL reset_we: got %b want 0", prog_we); end
      RST = 1'b1;
      idle(20);
      n_cmp++; if (cpu_rst_n !== 1'b0) begin n_bad++; $display("FAIL boot_hold: got %b want 0", cpu_rst_n); end
   endtask

   task automatic test_good_frame();
      for (int i = 0; i < 16; i++) frm[i] = 8'(i);
      clear_log();
      send_frame(8'h78);
      for (int i = 0; i < 16; i++) ram_model[i] = frm[i];
      n_cmp++; if (wr_adr.size() !== 16) begin n_bad++; $display("FAIL good_wr_count: got %0d want 16", wr_adr.size()); end
      for (int i = 0; i < 16 && i < wr_adr.size(); i++) begin
         n_cmp++;
         if (wr_adr[i] !== 4'(i) || wr_din[i] !== frm[i]) begin
            n_bad++;
            $display("FAIL good_wr[%0d]: got adr %h din %h want adr %h din %h", i, wr_adr[i], wr_din[i], 4'(i), frm[i]);
         end
      end
      n_cmp++; if (done !== 1'b1)      begin n_bad++; $display("FAIL good_done: got %b want 1", done); end
      n_cmp++; if (cpu_rst_n !== 1'b1) begin n_bad++; $display("FAIL good_cpu_rst_n: got %b want 1", cpu_rst_n); end
      n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL good_busy: got %b want 0", busy); end
      n_cmp++; if (err_code !== 2'd0)  begin n_bad++; $display("FAIL good_err: got %0d want 0", err_code); end
   endtask

   task automatic test_bad_csum();
      for (int i = 0; i < 16; i++) frm[i] = 8'hFF;
      clear_log();
      send_frame(8'h00);
      for (int i = 0; i < 16; i++) ram_model[i] = frm[i];
      n_cmp++; if (wr_adr.size() !== 16) begin n_bad++; $display("FAIL bad_wr_count: got %0d want 16", wr_adr.size()); end
      n_cmp++; if (err_code !== 2'd3)    begin n_bad++; $display("FAIL bad_err: got %0d want 3", err_code); end
      n_cmp++; if (cpu_rst_n !== 1'b0)   begin n_bad++; $display("FAIL bad_cpu_rst_n: got %b want 0", cpu_rst_n); end
      n_cmp++; if (done !== 1'b0)        begin n_bad++; $display("FAIL bad_done: got %b want 0", done); end
      n_cmp++; if (busy !== 1'b0)        begin n_bad++; $display("FAIL bad_busy: got %b want 0", busy); end
   endtask

   task automatic test_junk_then_random();
      logic [7:0] cs;
      clear_log();
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      send_byte(8'h56, 1'b1);
      n_cmp++; if (wr_adr.size() !== 0) begin n_bad++; $display("FAIL junk_writes: got %0d want 0", wr_adr.size()); end
      n_cmp++; if (err_code !== 2'd3)   begin n_bad++; $display("FAIL junk_err_sticky: got %0d want 3", err_code); end
      n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL junk_busy: got %b want 0", busy); end
      for (int i = 0; i < 16; i++) frm[i] = 8'($urandom);
      frm[5] = 8'hA5;   // sync value inside the data is plain data
      cs = model_sum();
      send_frame(cs);
      for (int i = 0; i < 16; i++) ram_model[i] = frm[i];
      n_cmp++; if (wr_adr.size() !== 16) begin n_bad++; $display("FAIL rnd_wr_count: got %0d want 16", wr_adr.size()); end
      for (int i = 0; i < 16 && i < wr_adr.size(); i++) begin
         n_cmp++;
         if (wr_adr[i] !== 4'(i) || wr_din[i] !== frm[i]) begin
            n_bad++;
            $display("FAIL rnd_wr[%0d]: got adr %h din %h want adr %h din %h", i, wr_adr[i], wr_din[i], 4'(i), frm[i]);
         end
      end
      n_cmp++; if (done !== 1'b1)      begin n_bad++; $display("FAIL rnd_done: got %b want 1", done); end
      n_cmp++; if (cpu_rst_n !== 1'b1) begin n_bad++; $display("FAIL rnd_cpu_rst_n: got %b want 1", cpu_rst_n); end
      n_cmp++; if (err_code !== 2'd0)  begin n_bad++; $display("FAIL rnd_err: got %0d want 0", err_code); end
   endtask

   task automatic test_timeout();
      for (int i = 0; i < 16; i++) frm[i] = 8'($urandom);
      clear_log();
      send_byte(8'hA5, 1'b1);
      for (int i = 0; i < 5; i++) send_byte(frm[i], 1'b1);
      for (int i = 0; i < 5; i++) ram_model[i] = frm[i];
      n_cmp++; if (busy !== 1'b1)       begin n_bad++; $display("FAIL tmo_busy_mid: got %b want 1", busy); end
      n_cmp++; if (cpu_rst_n !== 1'b0)  begin n_bad++; $display("FAIL tmo_cpu_rst_n: got %b want 0", cpu_rst_n); end
      n_cmp++; if (wr_adr.size() !== 5) begin n_bad++; $display("FAIL tmo_wr_count: got %0d want 5", wr_adr.size()); end
      idle(300);
      n_cmp++; if (err_code !== 2'd0)   begin n_bad++; $display("FAIL tmo_early: got %0d want 0", err_code); end
      idle(120);
      n_cmp++; if (err_code !== 2'd2)   begin n_bad++; $display("FAIL tmo_err: got %0d want 2", err_code); end
      n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL tmo_busy: got %b want 0", busy); end
      send_byte(8'hA5, 1'b1);
      n_cmp++; if (err_code !== 2'd0)   begin n_bad++; $display("FAIL resync_err: got %0d want 0", err_code); end
      n_cmp++; if (busy !== 1'b1)       begin n_bad++; $display("FAIL resync_busy: got %b want 1", busy); end
   endtask

   task automatic test_framing();
      for (int i = 0; i < 16; i++) frm[i] = 8'($urandom);
      clear_log();
      for (int i = 0; i < 3; i++) send_byte(frm[i], 1'b1);
      send_byte(frm[3], 1'b0);
      idle(20);
      for (int i = 0; i < 3; i++) ram_model[i] = frm[i];
      n_cmp++; if (wr_adr.size() !== 3) begin n_bad++; $display("FAIL frm_wr_count: got %0d want 3", wr_adr.size()); end
      n_cmp++; if (err_code !== 2'd1)   begin n_bad++; $display("FAIL frm_err: got %0d want 1", err_code); end
      n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL frm_busy: got %b want 0", busy); end
      n_cmp++; if (cpu_rst_n !== 1'b0)  begin n_bad++; $display("FAIL frm_cpu_rst_n: got %b want 0", cpu_rst_n); end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 16; i++) frm[i] = 8'($urandom);
      clear_log();
      send_byte(8'hA5, 1'b1);
      for (int i = 0; i < 4; i++) send_byte(frm[i], 1'b1);
      for (int i = 0; i < 4; i++) ram_model[i] = frm[i];
      RXD = 1'b0;            // part-way through the fifth byte
      idle(40);
      RST = 1'b0;
      idle(1);
      n_cmp++; if (prog_we !== 1'b0)   begin n_bad++; $display("FAIL mrst_we: got %b want 0", prog_we); end
      n_cmp++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL mrst_busy: got %b want 0", busy); end
      n_cmp++; if (cpu_rst_n !== 1'b0) begin n_bad++; $display("FAIL mrst_cpu_rst_n: got %b want 0", cpu_rst_n); end
      RST = 1'b1;
      RXD = 1'b1;
      idle(200);
      n_cmp++; if (wr_adr.size() !== 4) begin n_bad++; $display("FAIL mrst_wr_count: got %0d want 4", wr_adr.size()); end
      n_cmp++; if (err_code !== 2'd0)   begin n_bad++; $display("FAIL mrst_err: got %0d want 0", err_code); end
   endtask

   task automatic test_glitch();
      clear_log();
      RXD = 1'b0;
      idle(8);
      RXD = 1'b1;
      idle(200);
      n_cmp++; if (wr_adr.size() !== 0) begin n_bad++; $display("FAIL glitch_writes: got %0d want 0", wr_adr.size()); end
      n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL glitch_busy: got %b want 0", busy); end
      n_cmp++; if (err_code !== 2'd0)   begin n_bad++; $display("FAIL glitch_err: got %0d want 0", err_code); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] cs;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 16; i++) frm[i] = 8'($urandom);
         cs = model_sum();
         clear_log();
         send_byte(8'hA5, 1'b1);
         n_cmp++; if (cpu_rst_n !== 1'b0) begin n_bad++; $display("FAIL b2b_sync_cpu_rst_n[%0d]: got %b want 0", r, cpu_rst_n); end
         n_cmp++; if (busy !== 1'b1)      begin n_bad++; $display("FAIL b2b_sync_busy[%0d]: got %b want 1", r, busy); end
         n_cmp++; if (done !== 1'b0)      begin n_bad++; $display("FAIL b2b_sync_done[%0d]: got %b want 0", r, done); end
         for (int i = 0; i < 16; i++) send_byte(frm[i], 1'b1);
         send_byte(cs, 1'b1);
         for (int i = 0; i < 16; i++) ram_model[i] = frm[i];
         n_cmp++; if (wr_adr.size() !== 16) begin n_bad++; $display("FAIL b2b_wr_count[%0d]: got %0d want 16", r, wr_adr.size()); end
         n_cmp++; if (done !== 1'b1)      begin n_bad++; $display("FAIL b2b_done[%0d]: got %b want 1", r, done); end
         n_cmp++; if (cpu_rst_n !== 1'b1) begin n_bad++; $display("FAIL b2b_cpu_rst_n[%0d]: got %b want 1", r, cpu_rst_n); end
      end
      for (int i = 0; i < 16; i++) begin
         n_cmp++;
         if (ram_seen[i] !== ram_model[i]) begin
            n_bad++;
            $display("FAIL ram[%0d]: got %h want %h", i, ram_seen[i], ram_model[i]);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         ram_seen[i]  = 8'h00;
         ram_model[i] = 8'h00;
      end
      @(negedge CLK);
      test_reset();
      test_good_frame();
      test_bad_csum();
      test_junk_then_random();
      test_timeout();
      test_framing();
      test_mid_reset();
      test_glitch();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
